// File: rtl/irq_sched.sv
`default_nettype none
// ============================================================================
//  Module      : irq_sched
//  Description : Synchronises W5300/SL811 interrupts, latches pending flags
//                and paces fixed-length request pulses onto the ZX bus.
//  Revision    : 1.0 - initial release
// ============================================================================
module irq_sched #(
    parameter int PULSE_LEN = 32,
    parameter int GAP_LEN   = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       w5300_int_n,
    input  logic       sl811_intrq,
    input  logic       ena_w5300_int,
    input  logic       ena_sl811_int,
    input  logic       ena_zxbus_int,
    input  logic       ack_wr,
    input  logic [1:0] ack_data,
    output logic [1:0] pending,
    output logic [1:0] src,
    output logic       int_req,
    output logic       busy
);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_PULSE = 2'd1;
    localparam logic [1:0] c_GAP   = 2'd2;

    localparam logic [7:0] c_PULSE_LD = 8'(PULSE_LEN - 1);
    localparam logic [7:0] c_GAP_LD   = 8'(GAP_LEN - 1);

    logic [1:0] sync1_q, sync1_d;
    logic [1:0] sync2_q, sync2_d;
    logic [1:0] dly_q,   dly_d;
    logic [1:0] warm_q,  warm_d;
    logic [1:0] pending_q, pending_d;
    logic [1:0] src_q,   src_d;
    logic [1:0] state_q, state_d;
    logic [7:0] cnt_q,   cnt_d;
    logic       int_req_q, int_req_d;
    logic       busy_q,  busy_d;

    logic [1:0] w_rise;
    logic [1:0] w_ena;
    logic [1:0] w_clr;

    // Edge detection stays masked until the edge flop holds a post-reset
    // sample, so a source already active at reset release never looks like
    // a fresh edge.
    always_comb begin
        sync1_d = {sl811_intrq, ~w5300_int_n};
        sync2_d = sync1_q;
        dly_d   = sync2_q;
        warm_d  = (warm_q == 2'd3) ? warm_q : warm_q + 2'd1;
        w_rise  = sync2_q & ~dly_q & {2{warm_q == 2'd3}};
        w_ena   = {ena_sl811_int, ena_w5300_int};
        w_clr   = ack_wr ? ack_data : 2'b00;
        // Set is OR-ed after the clear so it wins on a same-cycle collision.
        pending_d = ((pending_q & ~w_clr) | w_rise) & w_ena;
    end

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        cnt_d   = (cnt_q != 8'd0) ? cnt_q - 8'd1 : 8'd0;
        case (state_q)
            c_IDLE: begin
                if ((pending_q != 2'b00) && ena_zxbus_int) begin
                    state_d = c_PULSE;
                    cnt_d   = c_PULSE_LD;
                    src_d   = pending_q[0] ? 2'b01 : 2'b10;
                end
            end
            c_PULSE: begin
                if (!ena_zxbus_int || (cnt_q == 8'd0)) begin
                    state_d = c_GAP;
                    cnt_d   = c_GAP_LD;
                end
            end
            c_GAP: begin
                if (cnt_q == 8'd0) begin
                    state_d = c_IDLE;
                end
            end
            default: begin
                state_d = c_IDLE;
                cnt_d   = 8'd0;
            end
        endcase
        int_req_d = (state_d == c_PULSE);
        busy_d    = (state_d != c_IDLE);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 2'b00;
            sync2_q   <= 2'b00;
            dly_q     <= 2'b00;
            warm_q    <= 2'd0;
            pending_q <= 2'b00;
            src_q     <= 2'b00;
            state_q   <= c_IDLE;
            cnt_q     <= 8'd0;
            int_req_q <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            dly_q     <= dly_d;
            warm_q    <= warm_d;
            pending_q <= pending_d;
            src_q     <= src_d;
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            int_req_q <= int_req_d;
            busy_q    <= busy_d;
        end
    end

    assign pending = pending_q;
    assign src     = src_q;
    assign int_req = int_req_q;
    assign busy    = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_sched.sv
`default_nettype none
// ============================================================================
//  Module      : tb_irq_sched
//  Description : Table-driven and directed self-checking bench for irq_sched.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_sched;

    logic       clk = 1'b0;
    logic       rst;
    logic       w5300_int_n;
    logic       sl811_intrq;
    logic       ena_w5300_int;
    logic       ena_sl811_int;
    logic       ena_zxbus_int;
    logic       ack_wr;
    logic [1:0] ack_data;
    logic [1:0] pending;
    logic [1:0] src;
    logic       int_req;
    logic       busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    irq_sched #(.PULSE_LEN(32), .GAP_LEN(16)) dut (
        .clk           (clk),
        .rst           (rst),
        .w5300_int_n   (w5300_int_n),
        .sl811_intrq   (sl811_intrq),
        .ena_w5300_int (ena_w5300_int),
        .ena_sl811_int (ena_sl811_int),
        .ena_zxbus_int (ena_zxbus_int),
        .ack_wr        (ack_wr),
        .ack_data      (ack_data),
        .pending       (pending),
        .src           (src),
        .int_req       (int_req),
        .busy          (busy)
    );

    typedef struct {
        bit         ew;
        bit         es;
        bit         ez;
        bit         fw;
        bit         fs;
        logic [1:0] exp_pend;
        logic [1:0] exp_src;
        bit         exp_int;
    } vec_t;

    vec_t vecs[6];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        w5300_int_n = 1'b1;
        sl811_intrq = 1'b0;
        ack_wr = 1'b0;
        ack_data = 2'b00;
        tick();
        tick();
        rst = 1'b0;
        repeat (3) tick();
    endtask

    task automatic set_ena(input bit ew, input bit es, input bit ez);
        ena_w5300_int = ew;
        ena_sl811_int = es;
        ena_zxbus_int = ez;
    endtask

    // Counts high cycles of int_req; optionally acks or drops ena_zxbus_int at a given high cycle.
    task automatic measure_high(input int ack_at, input logic [1:0] ad, input int drop_at, output int n);
        n = 0;
        while (int_req === 1'b1 && n < 300) begin
            ack_wr   = (n == ack_at);
            ack_data = (n == ack_at) ? ad : 2'b00;
            if (n == drop_at) ena_zxbus_int = 1'b0;
            n++;
            tick();
        end
        ack_wr = 1'b0;
        ack_data = 2'b00;
    endtask

    task automatic measure_low(output int n);
        n = 0;
        while (int_req === 1'b0 && n < 300) begin
            n++;
            tick();
        end
    endtask

    task automatic count_highs(input int cycles, output int h);
        h = 0;
        for (int k = 0; k < cycles; k++) begin
            if (int_req === 1'b1) h++;
            tick();
        end
    endtask

    initial begin
        int n;
        int h;

        //           ew    es    ez    fw    fs    pend   src    int
        vecs[0] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 2'b01, 2'b01, 1'b1};
        vecs[1] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 2'b10, 1'b1};
        vecs[2] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 2'b11, 2'b01, 1'b1};
        vecs[3] = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 2'b00, 2'b00, 1'b0};
        vecs[4] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 2'b01, 2'b00, 1'b0};
        vecs[5] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 2'b01, 2'b01, 1'b1};

        set_ena(1'b1, 1'b1, 1'b1);
        do_reset();
        check("reset_pending", 32'(pending), 0);
        check("reset_src",     32'(src),     0);
        check("reset_int_req", 32'(int_req), 0);
        check("reset_busy",    32'(busy),    0);

        // Table: edge -> pending latency, priority and enables
        for (int i = 0; i < 6; i++) begin
            set_ena(vecs[i].ew, vecs[i].es, vecs[i].ez);
            do_reset();
            w5300_int_n = ~vecs[i].fw;
            sl811_intrq = vecs[i].fs;
            tick();
            tick();
            check($sformatf("vec%0d_pend_t2", i), 32'(pending), 0);
            tick();
            check($sformatf("vec%0d_pend_t3", i), 32'(pending), 32'(vecs[i].exp_pend));
            tick();
            check($sformatf("vec%0d_int_t4", i),  32'(int_req), 32'(vecs[i].exp_int));
            check($sformatf("vec%0d_busy_t4", i), 32'(busy),    32'(vecs[i].exp_int));
            check($sformatf("vec%0d_src_t4", i),  32'(src),     32'(vecs[i].exp_src));
        end

        // Retrigger without ack, then ack during a pulse
        set_ena(1'b1, 1'b1, 1'b1);
        do_reset();
        w5300_int_n = 1'b0;
        repeat (4) tick();
        measure_high(-1, 2'b00, -1, n);
        check("retrig_high1", 32'(n), 32);
        measure_low(n);
        check("retrig_low1", 32'(n), 17);
        measure_high(-1, 2'b00, -1, n);
        check("retrig_high2", 32'(n), 32);
        measure_low(n);
        check("retrig_low2", 32'(n), 17);
        measure_high(5, 2'b01, -1, n);
        check("ack_full_pulse", 32'(n), 32);
        check("ack_pending", 32'(pending), 0);
        count_highs(80, h);
        check("ack_no_more_pulses", 32'(h), 0);
        check("ack_busy_idle", 32'(busy), 0);

        // Both sources together: W5300 first, SL811 after the gap
        do_reset();
        w5300_int_n = 1'b0;
        sl811_intrq = 1'b1;
        repeat (4) tick();
        check("both_src1", 32'(src), 32'b01);
        check("both_pend", 32'(pending), 32'b11);
        measure_high(3, 2'b01, -1, n);
        check("both_high1", 32'(n), 32);
        check("both_pend_after_ack", 32'(pending), 32'b10);
        measure_low(n);
        check("both_low", 32'(n), 17);
        check("both_src2", 32'(src), 32'b10);
        measure_high(-1, 2'b00, -1, n);
        check("both_high2", 32'(n), 32);
        check("both_pend_held", 32'(pending), 32'b10);
        ack_wr = 1'b1;
        ack_data = 2'b10;
        tick();
        ack_wr = 1'b0;
        ack_data = 2'b00;
        check("both_pend_cleared", 32'(pending), 0);
        check("both_src_holds", 32'(src), 32'b10);

        // Abort via ena_zxbus_int in the 10th high clock
        do_reset();
        w5300_int_n = 1'b0;
        repeat (4) tick();
        measure_high(-1, 2'b00, 9, n);
        check("abort_high", 32'(n), 10);
        n = 0;
        while (busy === 1'b1 && n < 100) begin
            if (int_req !== 1'b0) n = 200;
            n++;
            tick();
        end
        check("abort_gap", 32'(n), 16);
        check("abort_pending", 32'(pending), 32'b01);
        count_highs(20, h);
        check("abort_no_pulse", 32'(h), 0);

        // Reset in the 5th pulse clock with W5300 held active across reset
        set_ena(1'b1, 1'b1, 1'b1);
        do_reset();
        w5300_int_n = 1'b0;
        repeat (4) tick();
        repeat (4) tick();
        check("rstp_int_before", 32'(int_req), 1);
        rst = 1'b1;
        tick();
        check("rstp_int",  32'(int_req), 0);
        check("rstp_pend", 32'(pending), 0);
        check("rstp_busy", 32'(busy),    0);
        check("rstp_src",  32'(src),     0);
        rst = 1'b0;
        count_highs(60, h);
        check("rstp_no_pulse", 32'(h), 0);
        check("rstp_pend_after", 32'(pending), 0);

        // SL811 disabled while toggling; ack collides with a new W5300 edge
        set_ena(1'b1, 1'b0, 1'b0);
        do_reset();
        for (int k = 0; k < 10; k++) begin
            sl811_intrq = ~sl811_intrq;
            tick();
            tick();
        end
        check("sl_dis_pend", 32'(pending), 0);
        w5300_int_n = 1'b0;
        repeat (3) tick();
        check("col_pend_set", 32'(pending), 32'b01);
        w5300_int_n = 1'b1;
        repeat (4) tick();
        w5300_int_n = 1'b0;
        tick();
        tick();
        ack_wr = 1'b1;
        ack_data = 2'b01;
        tick();
        ack_wr = 1'b0;
        ack_data = 2'b00;
        check("col_set_wins", 32'(pending), 32'b01);
        ack_wr = 1'b1;
        ack_data = 2'b01;
        tick();
        ack_wr = 1'b0;
        ack_data = 2'b00;
        check("col_plain_ack", 32'(pending), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
`default_nettype wire
